// File: rtl/slow_tick_receiver.sv
// slow_tick_receiver: synchronizes a divided slow clock into clk_in and emits per-edge tick enables
// Optional feature: define TICK_BOTH_EDGES_EN to also tick on slow_clk falling edges.
module slow_tick_receiver #(
  parameter int          SYNC_STAGES = 2,
  parameter logic [27:0] TIMEOUT_CYC = 28'd200000000,
  parameter int          CNT_W       = 16
) (
  input  logic             clk_in,
  input  logic             reset_in,
  input  logic             slow_clk,
  input  logic             enable,
  output logic             tick,
  output logic [CNT_W-1:0] tick_count,
  output logic [27:0]      period,
  output logic             period_valid,
  output logic             stalled,
  output logic [1:0]       state
);
  localparam logic [1:0] ST_WAIT  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_STALL = 2'd2;
  localparam logic [27:0] GAP_MAX = 28'hFFFFFFF;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic                   tick_q, tick_d;
  logic [CNT_W-1:0]       tick_count_q, tick_count_d;
  logic [27:0]            gap_q, gap_d;
  logic [27:0]            period_q, period_d;
  logic                   period_valid_q, period_valid_d;
  logic                   stalled_q, stalled_d;
  logic [1:0]             state_q, state_d;
  logic                   sync_last, rise, fall, edge_hit, timeout;

  // Edge detection on the synchronized slow clock, tick gating and gap counting
  always_comb begin
    sync_last    = sync_q[SYNC_STAGES-1];
    sync_d       = {sync_q[SYNC_STAGES-2:0], slow_clk};
    prev_d       = sync_last;
    rise         = sync_last & ~prev_q;
    fall         = ~sync_last & prev_q;
`ifdef TICK_BOTH_EDGES_EN
    edge_hit     = rise | fall;
`else
    edge_hit     = rise;
`endif
    tick_d       = edge_hit & enable;
    tick_count_d = tick_count_q + {{(CNT_W-1){1'b0}}, tick_d};
    gap_d        = rise ? 28'd0 : (gap_q == GAP_MAX ? gap_q : gap_q + 28'd1);
    timeout      = gap_q == TIMEOUT_CYC - 28'd1;
  end

  // Link FSM: first-edge wait, period measurement while running, stall detection
  always_comb begin
    state_d        = state_q;
    period_d       = period_q;
    period_valid_d = period_valid_q;
    stalled_d      = stalled_q;
    case (state_q)
      ST_WAIT:  state_d = rise ? ST_RUN : ST_WAIT;
      ST_RUN: begin
        if (rise) begin
          period_d       = gap_q + 28'd1;
          period_valid_d = 1'b1;
        end else if (timeout) begin
          state_d        = ST_STALL;
          stalled_d      = 1'b1;
          period_valid_d = 1'b0;
        end
      end
      ST_STALL: begin
        state_d   = rise ? ST_RUN : ST_STALL;
        stalled_d = rise ? 1'b0 : 1'b1;
      end
      default: begin
        state_d        = ST_WAIT;
        stalled_d      = 1'b0;
        period_valid_d = 1'b0;
      end
    endcase
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk_in) begin
    if (!reset_in) begin
      sync_q         <= '0;
      prev_q         <= 1'b0;
      tick_q         <= 1'b0;
      tick_count_q   <= '0;
      gap_q          <= '0;
      period_q       <= '0;
      period_valid_q <= 1'b0;
      stalled_q      <= 1'b0;
      state_q        <= ST_WAIT;
    end else begin
      sync_q         <= sync_d;
      prev_q         <= prev_d;
      tick_q         <= tick_d;
      tick_count_q   <= tick_count_d;
      gap_q          <= gap_d;
      period_q       <= period_d;
      period_valid_q <= period_valid_d;
      stalled_q      <= stalled_d;
      state_q        <= state_d;
    end
  end

  assign tick         = tick_q;
  assign tick_count   = tick_count_q;
  assign period       = period_q;
  assign period_valid = period_valid_q;
  assign stalled      = stalled_q;
  assign state        = state_q;
endmodule

// File: tb/tb_slow_tick_receiver.sv
// tb_slow_tick_receiver: scenario tasks plus randomized run against a sample-history reference model
module tb_slow_tick_receiver;
  localparam int S = 2;
  localparam int T = 50;
  localparam int W = 16;

  logic clk_in = 1'b0, reset_in = 1'b0, slow_clk = 1'b0, enable = 1'b1;
  logic tick, period_valid, stalled;
  logic [W-1:0] tick_count;
  logic [27:0] period;
  logic [1:0] state;
  int checks = 0, errors = 0;
  int half = 0, ph = 0;

  always #5 clk_in = ~clk_in;

  slow_tick_receiver #(.SYNC_STAGES(S), .TIMEOUT_CYC(28'd50), .CNT_W(W)) dut (
    .clk_in(clk_in), .reset_in(reset_in), .slow_clk(slow_clk), .enable(enable),
    .tick(tick), .tick_count(tick_count), .period(period), .period_valid(period_valid),
    .stalled(stalled), .state(state)
  );

  // Reference model: slow_clk samples delayed through the sync depth; edges timed by cycle index
  int cyc = 0, last_rise = 0, m_period = 0, m_state = 0;
  logic hist[$];
  logic m_tick = 1'b0, m_pv = 1'b0, m_stalled = 1'b0;
  logic [W-1:0] m_count = '0;
  always @(posedge clk_in) begin
    logic r, f;
    cyc++;
    if (!reset_in) begin
      hist = {};
      for (int i = 0; i <= S; i++) hist.push_back(1'b0);
      m_tick = 0; m_count = 0; m_period = 0; m_pv = 0; m_stalled = 0; m_state = 0;
      last_rise = cyc;
    end else begin
      r = hist[S-1] & ~hist[S];
      f = ~hist[S-1] & hist[S];
`ifdef TICK_BOTH_EDGES_EN
      m_tick = (r | f) & enable;
`else
      m_tick = r & enable;
`endif
      if (m_tick) m_count++;
      if (m_state == 0) begin
        if (r) m_state = 1;
      end else if (m_state == 1) begin
        if (r) begin
          m_period = cyc - last_rise;
          m_pv = 1;
        end else if (cyc - last_rise == T) begin
          m_state = 2; m_stalled = 1; m_pv = 0;
        end
      end else if (r) begin
        m_state = 1; m_stalled = 0;
      end
      if (r) last_rise = cyc;
      hist.push_front(slow_clk);
      void'(hist.pop_back());
    end
  end

  logic [W+32:0] obs, expv;
  assign obs  = {tick, tick_count, period, period_valid, stalled, state};
  assign expv = {m_tick, m_count, 28'(m_period), m_pv, m_stalled, 2'(m_state)};

  task automatic step();
    @(negedge clk_in);
    if (half > 0 && ++ph >= half) begin
      ph = 0;
      slow_clk = ~slow_clk;
    end
  endtask

  task automatic do_reset();
    @(negedge clk_in);
    reset_in = 1'b0; half = 0; ph = 0; slow_clk = 1'b0; enable = 1'b1;
    @(negedge clk_in);
    reset_in = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (obs !== '0) begin errors++; $display("FAIL reset: got %h want 0", obs); end
    repeat (4) step();
    checks++;
    if (obs !== expv) begin errors++; $display("FAIL reset_idle: got %h want %h", obs, expv); end
  endtask

  task automatic test_basic();
    int n;
    do_reset();
    repeat (4) step();
    slow_clk = 1'b1; half = 5; ph = 0;
    n = 0;
    do begin
      step(); n++;
      checks++;
      if (obs !== expv) begin errors++; $display("FAIL basic_model: got %h want %h", obs, expv); end
    end while (!tick && n < 10);
    checks++;
    if (n !== 3 || state !== 2'd1) begin errors++; $display("FAIL basic_latency: got %0d/state %0d want 3/1", n, state); end
    n = 0;
    while (tick_count != 8 && n < 150) begin
      step(); n++;
      checks++;
      if (obs !== expv) begin errors++; $display("FAIL basic_model: got %h want %h", obs, expv); end
    end
    checks++;
    if (tick_count !== 16'd8 || period !== 28'd10 || period_valid !== 1'b1) begin
      errors++; $display("FAIL basic_period: got cnt %0d per %0d pv %b want 8 10 1", tick_count, period, period_valid);
    end
  endtask

  task automatic test_enable();
    logic [W-1:0] c0;
    int ticks, n;
    c0 = m_count; ticks = 0;
    enable = 1'b0;
    repeat (30) begin
      step();
      if (tick) ticks++;
      checks++;
      if (obs !== expv) begin errors++; $display("FAIL enable_model: got %h want %h", obs, expv); end
    end
    checks++;
    if (ticks !== 0 || tick_count !== c0) begin errors++; $display("FAIL enable_frozen: got %0d ticks cnt %0d want 0 %0d", ticks, tick_count, c0); end
    enable = 1'b1; n = 0;
    do begin step(); n++; end while (!tick && n < 20);
    checks++;
    if (tick_count !== c0 + 16'd1 || period !== 28'd10) begin
      errors++; $display("FAIL enable_resume: got cnt %0d per %0d want %0d 10", tick_count, period, c0 + 16'd1);
    end
  endtask

  task automatic test_stall();
    int n;
    logic [W-1:0] c0;
    n = 0;
    while (!tick && n < 20) begin step(); n++; end
    half = 0; n = 0;
    while (!stalled && n < 80) begin
      step(); n++;
      checks++;
      if (obs !== expv) begin errors++; $display("FAIL stall_model: got %h want %h", obs, expv); end
    end
    checks++;
    if (n !== T || state !== 2'd2 || period_valid !== 1'b0 || period !== 28'd10) begin
      errors++; $display("FAIL stall_timing: got %0d cycles state %0d pv %b want %0d 2 0", n, state, period_valid, T);
    end
    c0 = tick_count;
    half = 5; ph = 0; n = 0;
    do begin step(); n++; end while (!tick && n < 30);
    checks++;
    if (state !== 2'd1 || stalled !== 1'b0 || tick_count !== c0 + 16'd1 || period_valid !== 1'b0) begin
      errors++; $display("FAIL stall_recover: got state %0d st %b cnt %0d pv %b want 1 0 %0d 0", state, stalled, tick_count, period_valid, c0 + 16'd1);
    end
    n = 0;
    while (!period_valid && n < 30) begin
      step(); n++;
      checks++;
      if (obs !== expv) begin errors++; $display("FAIL stall_model: got %h want %h", obs, expv); end
    end
    checks++;
    if (period_valid !== 1'b1 || period !== 28'd10) begin errors++; $display("FAIL stall_revalid: got pv %b per %0d want 1 10", period_valid, period); end
  endtask

  task automatic test_wrap();
    int n;
    @(negedge clk_in);
    force dut.tick_count_q = 16'hFFFF;
    #1 release dut.tick_count_q;
    m_count = 16'hFFFF;
    n = 0;
    do begin
      step(); n++;
      checks++;
      if (obs !== expv) begin errors++; $display("FAIL wrap_model: got %h want %h", obs, expv); end
    end while (!tick && n < 20);
    checks++;
    if (tick_count !== 16'd0) begin errors++; $display("FAIL wrap: got %0d want 0", tick_count); end
  endtask

  task automatic test_reset_mid();
    int n;
    step();
    reset_in = 1'b0;
    step();
    reset_in = 1'b1;
    checks++;
    if (obs !== '0) begin errors++; $display("FAIL midreset: got %h want 0", obs); end
    n = 0;
    do begin
      step(); n++;
      checks++;
      if (obs !== expv) begin errors++; $display("FAIL midreset_model: got %h want %h", obs, expv); end
    end while (!tick && n < 30);
    checks++;
    if (state !== 2'd1 || period !== 28'd0 || period_valid !== 1'b0) begin
      errors++; $display("FAIL midreset_first: got state %0d per %0d pv %b want 1 0 0", state, period, period_valid);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int s = 0; s < 14; s++) begin
      half = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 8));
      repeat ($urandom_range(20, 90)) begin
        enable = $urandom_range(0, 4) != 0;
        step();
        checks++;
        if (obs !== expv) begin errors++; $display("FAIL random_model: got %h want %h", obs, expv); end
      end
    end
  endtask

`ifdef TICK_BOTH_EDGES_EN
  task automatic test_both_edges();
    int n;
    do_reset();
    repeat (4) step();
    half = 5; ph = 0; n = 0;
    while (tick_count != 8 && n < 150) begin
      step(); n++;
      checks++;
      if (obs !== expv) begin errors++; $display("FAIL both_model: got %h want %h", obs, expv); end
    end
    checks++;
    if (tick_count !== 16'd8 || period !== 28'd10) begin errors++; $display("FAIL both_edges: got cnt %0d per %0d want 8 10", tick_count, period); end
  endtask
`endif

  initial begin
    test_reset();
`ifdef TICK_BOTH_EDGES_EN
    test_both_edges();
`else
    test_basic();
    test_enable();
    test_stall();
    test_wrap();
    test_reset_mid();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
